// File: rtl/weight_load_scheduler.sv
// ---------------------------------------------------------------------------
// weight_load_scheduler
//
// Purpose:
//   Queues weight-tile load descriptors from the layer controller, issues them
//   one at a time to the weight buffer loader through its one-cycle conf
//   interface, and ping-pongs the loads between two weight-buffer banks.
//   A filled bank is flagged ready for the PE array and stays ready until the
//   PE array releases it. Banks are filled strictly alternately 0,1,0,1,...
//
// Optional feature (macro WEIGHT_LOAD_SCHED_TIMEOUT_EN):
//   Defined   - watchdog counter in WAIT_START/WAIT_DONE; when it reaches
//               TIMEOUT_CYCLES the load is abandoned, err[2] is set and the
//               FSM returns to IDLE without committing a bank.
//   Undefined - no watchdog, err[2] is constant 0, waits are unbounded.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   desc_valid/ready    descriptor handshake (ready = queue not full)
//   desc_ddr_addr       DDR start address of the tile
//   desc_weight_num     number of weights in the tile
//   ld_conf             one-cycle load start pulse to the loader
//   ld_ddr_st_addr      loader DDR start address
//   ld_weight_num       loader weight count
//   ld_weight_ddr_byte  loader DDR byte length (weights*9*X_PE*X_MESH)
//   ld_wb_st_addr       loader weight-buffer start address (bank base)
//   ld_idle             loader idle flag
//   bank_ready[1:0]     bank b holds a valid tile
//   bank0/1_weight_num  weight count held in each bank
//   bank_release[1:0]   one-cycle pulse, PE array finished with bank b
//   busy                FSM active or descriptors pending
//   err[2:0]            sticky: [0] illegal release, [1] zero-length
//                       descriptor, [2] watchdog timeout
// ---------------------------------------------------------------------------
module weight_load_scheduler #(
    parameter int DDR_ADDR_LEN   = 32,
    parameter int ADDR_LEN       = 16,
    parameter int SINGLE_LEN     = 24,
    parameter int X_PE           = 16,
    parameter int X_MESH         = 16,
    parameter int DESC_DEPTH     = 4,
    parameter int BANK_WORDS     = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [DDR_ADDR_LEN-1:0] desc_ddr_addr,
    input  logic [SINGLE_LEN-1:0]   desc_weight_num,
    output logic                    ld_conf,
    output logic [DDR_ADDR_LEN-1:0] ld_ddr_st_addr,
    output logic [SINGLE_LEN-1:0]   ld_weight_num,
    output logic [SINGLE_LEN-1:0]   ld_weight_ddr_byte,
    output logic [ADDR_LEN-1:0]     ld_wb_st_addr,
    input  logic                    ld_idle,
    output logic [1:0]              bank_ready,
    output logic [SINGLE_LEN-1:0]   bank0_weight_num,
    output logic [SINGLE_LEN-1:0]   bank1_weight_num,
    input  logic [1:0]              bank_release,
    output logic                    busy,
    output logic [2:0]              err
);

    localparam int PTR_W = $clog2(DESC_DEPTH);
    localparam logic [PTR_W:0]        DEPTH_CNT  = (PTR_W+1)'(DESC_DEPTH);
    localparam logic [ADDR_LEN-1:0]   BANK1_BASE = ADDR_LEN'(BANK_WORDS);
    localparam logic [SINGLE_LEN+31:0] BYTE_SCALE = (SINGLE_LEN+32)'(9 * X_PE * X_MESH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        COMMIT
    } state_t;

    state_t                  state;
    logic                    wr_bank;

    logic [DDR_ADDR_LEN-1:0] q_addr [DESC_DEPTH];
    logic [SINGLE_LEN-1:0]   q_num  [DESC_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count;
    logic [PTR_W:0]          count_next;

    logic                    push;
    logic                    pop;
    logic                    q_empty;
    logic                    head_zero;
    logic [DDR_ADDR_LEN-1:0] head_addr;
    logic [SINGLE_LEN-1:0]   head_num;
    logic [1:0]              commit_set;
    logic                    illegal_rel;

`ifdef WEIGHT_LOAD_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    // Counter value is the number of cycles already spent in the wait state,
    // so the hit fires on the TIMEOUT_CYCLES-th cycle.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    // DDR byte length of a tile; the product is formed wide and truncated.
    function automatic logic [SINGLE_LEN-1:0] byte_len(input logic [SINGLE_LEN-1:0] n);
        logic [SINGLE_LEN+31:0] p;
        p = {32'd0, n} * BYTE_SCALE;
        return p[SINGLE_LEN-1:0];
    endfunction

    always_comb begin
        head_addr   = q_addr[rd_ptr];
        head_num    = q_num[rd_ptr];
        q_empty     = (count == '0);
        head_zero   = (head_num == '0);
        push        = desc_valid && desc_ready;
        // Zero-length heads are discarded from IDLE; normal heads leave in ISSUE.
        pop         = ((state == IDLE) && !q_empty && head_zero) || (state == ISSUE);
        count_next  = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        commit_set  = 2'b00;
        if (state == COMMIT) begin
            commit_set = wr_bank ? 2'b10 : 2'b01;
        end
        illegal_rel = |(bank_release & ~bank_ready);
    end

    assign busy = (state != IDLE) || !q_empty;

    // Descriptor storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= desc_ddr_addr;
            q_num[wr_ptr]  <= desc_weight_num;
        end
    end

    // Control: queue pointers, FSM, bank bookkeeping, registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            wr_bank            <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            desc_ready         <= 1'b1;
            ld_conf            <= 1'b0;
            ld_ddr_st_addr     <= '0;
            ld_weight_num      <= '0;
            ld_weight_ddr_byte <= '0;
            ld_wb_st_addr      <= '0;
            bank_ready         <= 2'b00;
            bank0_weight_num   <= '0;
            bank1_weight_num   <= '0;
            err                <= 3'b000;
`ifdef WEIGHT_LOAD_SCHED_TIMEOUT_EN
            tmo_cnt            <= '0;
`endif
        end else begin
            ld_conf    <= 1'b0;
            count      <= count_next;
            desc_ready <= (count_next != DEPTH_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            // A release only clears a bank that is ready; COMMIT only targets a
            // not-ready bank, so the two never touch the same bit legally.
            bank_ready <= (bank_ready & ~bank_release) | commit_set;
            if (illegal_rel) begin
                err[0] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        if (head_zero) begin
                            err[1] <= 1'b1;
                        end else if (!bank_ready[wr_bank]) begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    ld_conf            <= 1'b1;
                    ld_ddr_st_addr     <= head_addr;
                    ld_weight_num      <= head_num;
                    ld_weight_ddr_byte <= byte_len(head_num);
                    ld_wb_st_addr      <= wr_bank ? BANK1_BASE : '0;
                    state              <= WAIT_START;
`ifdef WEIGHT_LOAD_SCHED_TIMEOUT_EN
                    tmo_cnt            <= '0;
`endif
                end
                WAIT_START: begin
                    if (!ld_idle) begin
                        state <= WAIT_DONE;
`ifdef WEIGHT_LOAD_SCHED_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        err[2] <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    end
                end
                WAIT_DONE: begin
                    if (ld_idle) begin
                        state <= COMMIT;
`ifdef WEIGHT_LOAD_SCHED_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        err[2] <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    end
                end
                COMMIT: begin
                    if (wr_bank) begin
                        bank1_weight_num <= ld_weight_num;
                    end else begin
                        bank0_weight_num <= ld_weight_num;
                    end
                    wr_bank <= ~wr_bank;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_scheduler.sv
// ---------------------------------------------------------------------------
// tb_weight_load_scheduler
//
// Self-checking bench for weight_load_scheduler (default build). Stimulus
// pushes descriptors; a reference model predicts, for every non-zero
// descriptor, the loader command it must produce (bank chosen by its ordinal
// since reset) and the bank commit that follows. A monitor compares each
// ld_conf pulse and each rising bank_ready bit against those queues.
// A loader model answers ld_conf by dropping ld_idle for a while.
// ---------------------------------------------------------------------------
module tb_weight_load_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_ddr_addr = '0;
    logic [23:0] desc_weight_num = '0;
    logic        ld_conf;
    logic [31:0] ld_ddr_st_addr;
    logic [23:0] ld_weight_num;
    logic [23:0] ld_weight_ddr_byte;
    logic [15:0] ld_wb_st_addr;
    logic        ld_idle;
    logic [1:0]  bank_ready;
    logic [23:0] bank0_weight_num;
    logic [23:0] bank1_weight_num;
    logic [1:0]  bank_release = 2'b00;
    logic        busy;
    logic [2:0]  err;

    weight_load_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_ddr_addr      (desc_ddr_addr),
        .desc_weight_num    (desc_weight_num),
        .ld_conf            (ld_conf),
        .ld_ddr_st_addr     (ld_ddr_st_addr),
        .ld_weight_num      (ld_weight_num),
        .ld_weight_ddr_byte (ld_weight_ddr_byte),
        .ld_wb_st_addr      (ld_wb_st_addr),
        .ld_idle            (ld_idle),
        .bank_ready         (bank_ready),
        .bank0_weight_num   (bank0_weight_num),
        .bank1_weight_num   (bank1_weight_num),
        .bank_release       (bank_release),
        .busy               (busy),
        .err                (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [23:0] num;
        logic [23:0] bytes;
        logic [15:0] wb;
    } load_t;

    typedef struct {
        int          bank;
        logic [23:0] num;
    } commit_t;

    load_t       exp_load[$];
    commit_t     exp_commit[$];
    int          checks = 0;
    int          errors = 0;
    int          conf_count = 0;
    int          nz_count = 0;
    logic [2:0]  exp_err = 3'b000;
    int          hold_cfg = 30;
    bit          stall = 1'b0;
    bit          auto_rel = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: the n-th non-zero descriptor since reset goes to bank n%2.
    function automatic void model_push(input logic [31:0] a, input logic [23:0] n);
        load_t   l;
        commit_t c;
        if (n == 24'd0) begin
            exp_err[1] = 1'b1;
        end else begin
            l.addr  = a;
            l.num   = n;
            l.bytes = 24'(64'(n) * 64'd2304);
            l.wb    = (nz_count % 2 == 1) ? 16'd1024 : 16'd0;
            exp_load.push_back(l);
            c.bank  = nz_count % 2;
            c.num   = n;
            exp_commit.push_back(c);
            nz_count++;
        end
    endfunction

    // Monitor / scoreboard.
    initial begin
        logic [1:0]  prev;
        load_t       e;
        commit_t     c;
        logic [23:0] got;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (ld_conf) begin
                conf_count++;
                if (exp_load.size() == 0) begin
                    chk("unexpected_ld_conf", 64'd1, 64'd0);
                end else begin
                    e = exp_load.pop_front();
                    chk("ld_ddr_st_addr", ld_ddr_st_addr, e.addr);
                    chk("ld_weight_num", ld_weight_num, e.num);
                    chk("ld_weight_ddr_byte", ld_weight_ddr_byte, e.bytes);
                    chk("ld_wb_st_addr", ld_wb_st_addr, e.wb);
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (bank_ready[b] && !prev[b]) begin
                    got = (b == 1) ? bank1_weight_num : bank0_weight_num;
                    if (exp_commit.size() == 0) begin
                        chk("unexpected_commit", 64'd1, 64'd0);
                    end else begin
                        c = exp_commit.pop_front();
                        chk("commit_bank", b, c.bank);
                        chk("commit_weight_num", got, c.num);
                    end
                end
            end
            prev = bank_ready;
        end
    end

    // Loader model: goes busy two cycles after ld_conf, stays busy for a hold.
    initial begin
        int h;
        ld_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (ld_conf && !rst) begin
                repeat (2) @(negedge clk);
                ld_idle = 1'b0;
                h = (hold_cfg > 0) ? hold_cfg : int'($urandom_range(1, 8));
                repeat (h) @(negedge clk);
                while (stall) @(negedge clk);
                ld_idle = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(negedge clk);
        bank_release = auto_rel ? (bank_ready & 2'($urandom_range(0, 3))) : 2'b00;
    endtask

    task automatic push(input logic [31:0] a, input logic [23:0] n, input int budget);
        int w;
        w = 0;
        desc_valid      = 1'b1;
        desc_ddr_addr   = a;
        desc_weight_num = n;
        while (!desc_ready && w < budget) begin
            tick();
            w++;
        end
        if (!desc_ready) begin
            chk("push_accept_timeout", desc_ready, 1);
            desc_valid = 1'b0;
            return;
        end
        model_push(a, n);
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_bank(input logic [1:0] v, input int budget, input string name);
        int w;
        w = 0;
        while (bank_ready !== v && w < budget) begin
            tick();
            w++;
        end
        chk(name, bank_ready, v);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int w;
        w = 0;
        while (!(exp_commit.size() == 0 && busy == 1'b0 && ld_idle == 1'b1) && w < budget) begin
            tick();
            w++;
        end
        chk({name, "_pending_commits"}, exp_commit.size(), 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    task automatic wait_loader_idle(input int budget);
        int w;
        w = 0;
        while (ld_idle !== 1'b1 && w < budget) begin
            tick();
            w++;
        end
    endtask

    task automatic reset_dut();
        auto_rel = 1'b0;
        stall    = 1'b0;
        wait_loader_idle(500);
        desc_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_load.delete();
        exp_commit.delete();
        nz_count = 0;
        exp_err  = 3'b000;
    endtask

    initial begin
        int          c0;
        logic [31:0] a;
        logic [23:0] n;

        // Reset state
        repeat (3) tick();
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_ld_conf", ld_conf, 0);
        chk("rst_bank_ready", bank_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ld_fields", {ld_ddr_st_addr, ld_weight_num, ld_weight_ddr_byte, ld_wb_st_addr}, 0);
        rst = 1'b0;
        tick();

        // Single load with latency check
        hold_cfg = 30;
        c0 = conf_count;
        push(32'h1000, 24'd3, 10);
        chk("lat_after_accept", ld_conf, 0);
        tick();
        chk("lat_edge1", ld_conf, 0);
        tick();
        chk("lat_edge2", ld_conf, 1);
        chk("t1_byte_len", ld_weight_ddr_byte, 24'd6912);
        chk("t1_wb_addr", ld_wb_st_addr, 0);
        wait_bank(2'b01, 200, "t1_bank_ready");
        chk("t1_bank0_num", bank0_weight_num, 3);
        chk("t1_busy", busy, 0);
        chk("t1_conf_count", conf_count - c0, 1);

        // Ping-pong with back-pressure from an unreleased bank
        reset_dut();
        hold_cfg = 10;
        c0 = conf_count;
        push(32'h2000, 24'd1, 10);
        push(32'h3000, 24'd2, 10);
        push(32'h4000, 24'd3, 10);
        wait_bank(2'b11, 300, "pp_both_ready");
        repeat (20) tick();
        chk("pp_third_stalled", conf_count - c0, 2);
        chk("pp_busy_stalled", busy, 1);
        bank_release = 2'b01;
        tick();
        chk("pp_after_release", bank_ready, 2'b10);
        wait_bank(2'b11, 300, "pp_third_done");
        chk("pp_conf_count", conf_count - c0, 3);

        // Queue full while the loader is stalled
        reset_dut();
        hold_cfg = 5;
        stall    = 1'b1;
        c0 = conf_count;
        for (int i = 0; i < 5; i++) begin
            push(32'h5000 + 32'(i * 16), 24'(i + 1), 20);
        end
        chk("qf_ready_low", desc_ready, 0);
        repeat (10) tick();
        chk("qf_ready_held_low", desc_ready, 0);
        chk("qf_one_in_flight", conf_count - c0, 1);
        stall    = 1'b0;
        auto_rel = 1'b1;
        push(32'h6000, 24'd6, 3000);
        wait_drain(3000, "qf_drain");
        chk("qf_conf_count", conf_count - c0, 6);
        auto_rel = 1'b0;

        // Zero-length descriptor and illegal release
        reset_dut();
        c0 = conf_count;
        push(32'h7000, 24'd0, 10);
        repeat (5) tick();
        chk("zero_no_conf", conf_count - c0, 0);
        chk("zero_err", err, 3'b010);
        chk("zero_model_err", err, exp_err);
        chk("zero_drained", busy, 0);
        bank_release = 2'b10;
        exp_err[0]   = 1'b1;
        tick();
        tick();
        chk("illegal_rel_err", err, 3'b011);
        chk("illegal_rel_banks", bank_ready, 2'b00);

        // Reset during WAIT_DONE
        reset_dut();
        hold_cfg = 30;
        push(32'h8000, 24'd7, 10);
        begin
            int w;
            w = 0;
            while (ld_idle && w < 50) begin
                tick();
                w++;
            end
            chk("midrst_loader_started", ld_idle, 0);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst_desc_ready", desc_ready, 1);
        chk("midrst_err", err, 0);
        chk("midrst_bank_ready", bank_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ld_conf", ld_conf, 0);
        chk("midrst_ld_fields", {ld_ddr_st_addr, ld_weight_num, ld_weight_ddr_byte, ld_wb_st_addr}, 0);
        rst = 1'b0;
        exp_commit.delete();
        nz_count = 0;
        wait_loader_idle(100);
        push(32'h9000, 24'd9, 10);
        wait_bank(2'b01, 200, "midrst_next_bank0");
        chk("midrst_bank0_num", bank0_weight_num, 9);

        // Randomized traffic with random releases and loader latency
        reset_dut();
        hold_cfg = 0;
        auto_rel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            n = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(1, 50));
            if (n == 24'd0) n = 24'd1;
            push(a, n, 3000);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(5000, "rand_drain");
        auto_rel = 1'b0;
        chk("rand_loads_left", exp_load.size(), 0);
        chk("rand_err", err, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
